// File: rtl/cpu_defs.sv
// Shared CPU definitions: data-bridge FSM encoding, bus size codes and the
// kseg0/kseg1 address-translation constants.
package cpu_defs;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StHold = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) share top bits 2'b10 and map to
    // physical memory by clearing bits [31:29].
    localparam logic [1:0]  KsegSel  = 2'b10;
    localparam logic [31:0] KsegMask = 32'h1FFF_FFFF;

    function automatic logic is_kseg(input logic [31:0] vaddr);
        return vaddr[31:30] == KsegSel;
    endfunction

endpackage

// File: rtl/addr_map.sv
// Purely combinational virtual-to-physical translation for the data bus.
module addr_map
    import cpu_defs::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if (is_kseg(vaddr)) begin
            paddr = vaddr & KsegMask;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: turns a pipeline load/store into one request on
// the addr_ok/data_ok bus and stalls the pipeline until the response arrives.
module dmem_bridge
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        pipe_stall,
    output logic [31:0] mem_rdata,
    output logic        stall_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    bridge_state_e state_q, state_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          req_c;
    logic          stall_c;
    logic          bus_wr_c;
    logic [1:0]    bus_size_c;
    logic [31:0]   bus_vaddr_c;
    logic [31:0]   bus_wdata_c;
    logic [31:0]   bus_paddr;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        req_c       = 1'b0;
        stall_c     = 1'b0;
        bus_wr_c    = wr_q;
        bus_size_c  = size_q;
        bus_vaddr_c = addr_q;
        bus_wdata_c = wdata_q;

        case (state_q)
            StIdle: begin
                if (mem_en) begin
                    // Request goes out in the same cycle, straight from the pipeline.
                    state_d     = StAddr;
                    wr_d        = |mem_wen;
                    size_d      = mem_size;
                    addr_d      = mem_addr;
                    wdata_d     = mem_wdata;
                    req_c       = 1'b1;
                    stall_c     = 1'b1;
                    bus_wr_c    = |mem_wen;
                    bus_size_c  = mem_size;
                    bus_vaddr_c = mem_addr;
                    bus_wdata_c = mem_wdata;
                end
            end
            StAddr: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = StHold;
                        rdata_d = data_rdata;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                stall_c = 1'b1;
                if (data_data_ok) begin
                    state_d = StHold;
                    rdata_d = data_rdata;
                end
            end
            StHold: begin
                // Wait for the frozen instruction to leave M before accepting another.
                if (!pipe_stall) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    addr_map u_addr_map (
        .vaddr (bus_vaddr_c),
        .paddr (bus_paddr)
    );

    // The IDLE path is combinational from the pipeline, so reset must gate it too.
    assign data_req   = rst & req_c;
    assign stall_mem  = rst & stall_c;
    assign data_wr    = rst & bus_wr_c;
    assign data_size  = rst ? bus_size_c  : 2'd0;
    assign data_addr  = rst ? bus_paddr   : 32'd0;
    assign data_wdata = rst ? bus_wdata_c : 32'd0;
    assign mem_rdata  = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
